xs3_scan_ctrl: RTL and testbench

Sequencer for an excess-3 one-of-ten decoder used as a multiplexed digit or keyboard column driver. It steps a 4-bit excess-3 code (a..d) through NDIG positions, inserting a blanking code between positions and holding each position for a programmable dwell. It samples a shared active-low key return line at the end of each dwell and debounces hits across whole scans. It reports one debounced key per press over a valid/ack handshake.

---
 rtl/xs3_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_xs3_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/xs3_scan_ctrl.sv
// Excess-3 one-of-ten scan sequencer: steps a blanked excess-3 code through NDIG
// positions, samples the key return at each dwell end, debounces and reports keys.
module xs3_scan_ctrl #(
  parameter int unsigned NDIG  = 10,
  parameter int unsigned DWELL = 8,
  parameter int unsigned BLANK = 1,
  parameter int unsigned DEB   = 2
) (
  input  logic       clk,
  input  logic       clr_,
  input  logic       run,
  input  logic       start,
  input  logic       ret_,
  input  logic       key_ack,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] pos,
  output logic       busy,
  output logic       scan_done,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned MAXT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned TW   = $clog2(MAXT + 1);
  localparam int unsigned PW   = 4;
  localparam int unsigned CW   = 3;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

  state_t          state_q, state_nx;
  logic [TW-1:0]   tmr_q, tmr_nx;
  logic [PW-1:0]   pos_nx;
  logic            os_q, os_nx;
  logic            hit_vld_q, hit_vld_nx;
  logic [PW-1:0]   hit_pos_q, hit_pos_nx;
  logic            cand_vld_q, cand_vld_nx;
  logic [PW-1:0]   cand_q, cand_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic            rep_q, rep_nx;
  logic [PW-1:0]   code_q, code_nx;
  logic            busy_nx, sd_nx, kv_nx;
  logic [PW-1:0]   kc_nx;
  logic            scan_end;
  logic            smp_vld;
  logic [PW-1:0]   smp_pos;

  assign {d, c, b, a} = code_q;

  // State and output registers
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      pos        <= '0;
      os_q       <= 1'b0;
      hit_vld_q  <= 1'b0;
      hit_pos_q  <= '0;
      cand_vld_q <= 1'b0;
      cand_q     <= '0;
      cnt_q      <= '0;
      rep_q      <= 1'b0;
      code_q     <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
    end else begin
      state_q    <= state_nx;
      tmr_q      <= tmr_nx;
      pos        <= pos_nx;
      os_q       <= os_nx;
      hit_vld_q  <= hit_vld_nx;
      hit_pos_q  <= hit_pos_nx;
      cand_vld_q <= cand_vld_nx;
      cand_q     <= cand_nx;
      cnt_q      <= cnt_nx;
      rep_q      <= rep_nx;
      code_q     <= code_nx;
      busy       <= busy_nx;
      scan_done  <= sd_nx;
      key_valid  <= kv_nx;
      key_code   <= kc_nx;
    end
  end

  // Next-state, scan sequencing, debounce and report
  always_comb begin
    state_nx    = state_q;
    tmr_nx      = tmr_q;
    pos_nx      = pos;
    os_nx       = os_q;
    hit_vld_nx  = hit_vld_q;
    hit_pos_nx  = hit_pos_q;
    cand_vld_nx = cand_vld_q;
    cand_nx     = cand_q;
    cnt_nx      = cnt_q;
    rep_nx      = rep_q;
    kv_nx       = key_valid;
    kc_nx       = key_code;
    scan_end    = 1'b0;
    // Running "lowest hit" including this dwell's sample
    smp_vld     = hit_vld_q | ~ret_;
    smp_pos     = hit_vld_q ? hit_pos_q : pos;

    case (state_q)
      S_IDLE: begin
        if (run || start) begin
          state_nx = S_BLANK;
          tmr_nx   = '0;
          pos_nx   = '0;
          os_nx    = start & ~run;
        end
      end
      S_BLANK: begin
        if (tmr_q == TW'(BLANK - 1)) begin
          state_nx = S_DWELL;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr_q + TW'(1);
        end
      end
      S_DWELL: begin
        if (tmr_q == TW'(DWELL - 1)) begin
          tmr_nx = '0;
          if (pos == PW'(NDIG - 1)) begin
            scan_end   = 1'b1;
            hit_vld_nx = 1'b0;
            hit_pos_nx = '0;
            pos_nx     = '0;
            if (run && !os_q) begin
              state_nx = S_BLANK;
            end else begin
              state_nx = S_IDLE;
              os_nx    = 1'b0;
            end
          end else begin
            state_nx   = S_BLANK;
            pos_nx     = pos + PW'(1);
            hit_vld_nx = smp_vld;
            hit_pos_nx = smp_pos;
          end
        end else begin
          tmr_nx = tmr_q + TW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (scan_end) begin
      if (!smp_vld) begin
        cand_vld_nx = 1'b0;
        cnt_nx      = '0;
        rep_nx      = 1'b0;
      end else if (cand_vld_q && (cand_q == smp_pos)) begin
        if (cnt_q < CW'(DEB)) cnt_nx = cnt_q + CW'(1);
      end else begin
        cand_vld_nx = 1'b1;
        cand_nx     = smp_pos;
        cnt_nx      = CW'(1);
      end
    end

    if (key_valid && key_ack) kv_nx = 1'b0;

    // A press arriving while a key is still pending is consumed silently
    if (scan_end && (cnt_nx == CW'(DEB)) && !rep_q) begin
      rep_nx = 1'b1;
      if (!key_valid) begin
        kv_nx = 1'b1;
        kc_nx = cand_nx;
      end
    end

    code_nx = (state_nx == S_DWELL) ? PW'(pos_nx + PW'(3)) : '0;
    busy_nx = (state_nx != S_IDLE);
    sd_nx   = scan_end;
  end

endmodule

// File: tb/tb_xs3_scan_ctrl.sv
// Bench for xs3_scan_ctrl: timing-offset reference model, random key patterns and acks.
module tb_xs3_scan_ctrl;

  localparam int NDIG  = 10;
  localparam int DWELL = 8;
  localparam int BLANK = 1;
  localparam int DEB   = 2;
  localparam int SLOT  = BLANK + DWELL;

  logic clk = 1'b0;
  logic clr_, run, start, ret_, key_ack;
  logic a, b, c, d, busy, scan_done, key_valid;
  logic [3:0] pos, key_code;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position derived from cycle offset within the scan
  bit m_busy, m_os, m_sd, m_kv, rep;
  int m_t, m_kc, cand, cnt, scan_hit, cur_mask, prev_mask;
  int mq[$];

  xs3_scan_ctrl dut (
    .clk(clk), .clr_(clr_), .run(run), .start(start), .ret_(ret_), .key_ack(key_ack),
    .a(a), .b(b), .c(c), .d(d), .pos(pos), .busy(busy), .scan_done(scan_done),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_mask();
    int m;
    if (mq.size() > 0) m = mq.pop_front();
    else begin
      case ($urandom_range(0, 5))
        0:       m = 0;
        1, 2:    m = prev_mask;
        3:       m = 1 << $urandom_range(0, NDIG - 1);
        4:       m = (1 << $urandom_range(0, NDIG - 1)) | (1 << $urandom_range(0, NDIG - 1));
        default: m = int'($urandom_range(0, (1 << NDIG) - 1));
      endcase
    end
    prev_mask = m;
    return m;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_os = 0; m_sd = 0; m_kv = 0; rep = 0;
    m_t = 0; m_kc = 0; cand = -1; cnt = 0; scan_hit = -1;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit k, input bit retv);
    bit kv_old;
    kv_old = m_kv;
    m_sd = 0;
    if (kv_old && k) m_kv = 0;
    if (!m_busy) begin
      if (r || s) begin
        m_busy = 1; m_t = 0; m_os = s && !r; scan_hit = -1;
        cur_mask = next_mask();
      end
    end else begin
      if ((m_t % SLOT == SLOT - 1) && !retv && scan_hit < 0) scan_hit = m_t / SLOT;
      m_t++;
      if (m_t == NDIG * SLOT) begin
        m_sd = 1;
        if (scan_hit < 0) begin
          cand = -1; cnt = 0; rep = 0;
        end else if (scan_hit == cand) begin
          if (cnt < DEB) cnt++;
        end else begin
          cand = scan_hit; cnt = 1;
        end
        if (cnt == DEB && !rep) begin
          rep = 1;
          if (!kv_old) begin m_kv = 1; m_kc = cand; end
        end
        scan_hit = -1;
        if (r && !m_os) begin
          m_t = 0;
          cur_mask = next_mask();
        end else begin
          m_busy = 0; m_os = 0; m_t = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int ep, ec;
    ep = m_busy ? m_t / SLOT : 0;
    ec = (m_busy && (m_t % SLOT >= BLANK)) ? ep + 3 : 0;
    check("code", 32'({d, c, b, a}), 32'(ec));
    check("pos", 32'(pos), 32'(ep));
    check("busy", 32'(busy), 32'(m_busy));
    check("scan_done", 32'(scan_done), 32'(m_sd));
    check("key_valid", 32'(key_valid), 32'(m_kv));
    check("key_code", 32'(key_code), 32'(m_kc));
  endtask

  // One clock: drive at negedge, model the edge, compare just after it
  task automatic step(input bit r, input bit s, input bit k);
    @(negedge clk);
    run = r; start = s; key_ack = k;
    if (m_busy && (m_t % SLOT == SLOT - 1)) ret_ = !cur_mask[m_t / SLOT];
    else ret_ = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge(r, s, k, ret_);
    #1;
    compare_all();
  endtask

  function automatic bit rnd_ack();
    return $urandom_range(0, 7) == 0;
  endfunction

  initial begin
    int bcnt, sdcnt, scans;
    bit started;
    clr_ = 1'b0; run = 1'b0; start = 1'b0; ret_ = 1'b1; key_ack = 1'b0;
    prev_mask = 0; cur_mask = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    @(negedge clk) clr_ = 1'b1;
    repeat (3) step(0, 0, 0);

    // One-shot scan
    bcnt = 0; sdcnt = 0;
    step(0, 1, 0);
    if (busy) bcnt++;
    repeat (100) begin
      step(0, 0, rnd_ack());
      if (busy) bcnt++;
      if (scan_done) sdcnt++;
    end
    check("oneshot_busy_len", 32'(bcnt), 32'(90));
    check("oneshot_sd_count", 32'(sdcnt), 32'(1));

    // Continuous: held key, re-press, multi-key, bounce, then random patterns
    mq = '{32'h80, 32'h80, 32'h80, 0, 32'h80, 32'h80, 32'h24, 32'h24, 0, 32'h08, 0, 32'h08, 32'h08};
    scans = 0;
    while (scans < 28) begin
      step(1, 0, rnd_ack());
      if (m_sd) scans++;
    end

    // Drop run at pos 4, start pulse at pos 6 must be ignored
    while (m_t / SLOT != 4) step(1, 0, rnd_ack());
    sdcnt = 0; started = 0;
    while (m_busy) begin
      if (!started && m_t / SLOT == 6 && m_t % SLOT == 0) begin
        started = 1;
        step(0, 1, rnd_ack());
      end else step(0, 0, rnd_ack());
      if (scan_done) sdcnt++;
    end
    repeat (12) step(0, 0, 0);
    check("runstop_sd_count", 32'(sdcnt), 32'(1));
    check("runstop_idle", 32'(busy), 32'(0));

    // Asynchronous clear in the middle of the pos-4 dwell
    step(1, 0, 0);
    while (!(m_busy && m_t == 4 * SLOT + BLANK + 2)) step(1, 0, 0);
    #2 clr_ = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk) run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) clr_ = 1'b1;
    repeat (5) step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
